// File: rtl/vdp_port_ctrl.sv
// Z80-side VDP port controller: control-word assembly, register file, read-ahead buffer, status/IRQ.
// Accesses arriving while a VRAM/CRAM request is outstanding wait in a one-entry slot; WAIT_L stretches the CPU.
module vdp_port_ctrl #(
  parameter int         ADDR_W    = 14,
  parameter int         CRAM_AW   = 5,
  parameter int         NUM_REGS  = 11,
  parameter logic [7:0] DATA_PORT = 8'hBE,
  parameter logic [7:0] CTRL_PORT = 8'hBF,
  parameter logic [7:0] PORT_MASK = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [7:0]            addr_in,
  input  logic [7:0]            data_in,
  input  logic                  IORQ_L,
  input  logic                  RD_L,
  input  logic                  WR_L,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  output logic                  WAIT_L,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_cram,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  input  logic                  mem_ack,
  input  logic [2:0]            status_set,
  output logic [8*NUM_REGS-1:0] regs,
  output logic                  irq_L
);

  localparam logic [0:0]        S_IDLE    = 1'b0;
  localparam logic [0:0]        S_REQ     = 1'b1;
  localparam logic [ADDR_W-1:0] CRAM_MASK = ADDR_W'((1 << CRAM_AW) - 1);

  logic                  rd_act, wr_act, rd_act_q, wr_act_q, rd_ev, wr_ev;
  logic                  sel_data, sel_ctrl, bus_ev, bus_ctrl;
  logic [0:0]            state_q;
  logic                  idle, use_pend, stash, exec_vld, exec_ctrl, exec_wr;
  logic [7:0]            exec_dat;
  logic                  pend_vld_q, pend_ctrl_q, pend_wr_q;
  logic [7:0]            pend_dat_q;
  logic [ADDR_W-1:0]     addr_q, new_addr, iss_addr;
  logic [1:0]            code_q;
  logic [7:0]            latch_q, buf_q;
  logic [2:0]            status_q;
  logic                  flag_q;
  logic [8*NUM_REGS-1:0] regs_q;
  logic                  ctrl_wr2, reg_we, issue, iss_we, iss_cram;
  logic [3:0]            reg_idx;
  logic                  mem_we_q, mem_cram_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [7:0]            mem_wdata_q, data_out_q;
  logic                  data_oe_q;

  // A cycle counts as one access on the rising edge of (IORQ and strobe both active).
  assign rd_act   = ~IORQ_L & ~RD_L;
  assign wr_act   = ~IORQ_L & ~WR_L;
  assign rd_ev    = rd_act & ~rd_act_q;
  assign wr_ev    = wr_act & ~wr_act_q;
  assign sel_data = ((addr_in ^ DATA_PORT) & PORT_MASK) == 8'h00;
  assign sel_ctrl = ((addr_in ^ CTRL_PORT) & PORT_MASK) == 8'h00;
  assign bus_ev   = (rd_ev | wr_ev) & (sel_data | sel_ctrl);
  assign bus_ctrl = ~sel_data;

  // The pending slot always runs before a fresh bus access; a fresh one then takes the slot.
  assign idle      = (state_q == S_IDLE);
  assign use_pend  = idle & pend_vld_q;
  assign stash     = bus_ev & (use_pend | (~idle & ~pend_vld_q));
  assign exec_vld  = idle & (pend_vld_q | bus_ev);
  assign exec_ctrl = use_pend ? pend_ctrl_q : bus_ctrl;
  assign exec_wr   = use_pend ? pend_wr_q   : wr_ev;
  assign exec_dat  = use_pend ? pend_dat_q  : data_in;

  assign ctrl_wr2 = exec_vld & exec_ctrl & exec_wr & flag_q;
  assign new_addr = ADDR_W'({exec_dat[5:0], latch_q});
  assign reg_idx  = exec_dat[3:0];
  assign reg_we   = ctrl_wr2 & (exec_dat[7:6] == 2'd2) & (32'(reg_idx) < NUM_REGS);

  assign iss_we   = exec_wr & ~exec_ctrl;
  assign iss_cram = iss_we & (code_q == 2'd3);
  assign issue    = (exec_vld & ~exec_ctrl) | (ctrl_wr2 & (exec_dat[7:6] == 2'd0));
  assign iss_addr = exec_ctrl ? new_addr : (iss_cram ? (addr_q & CRAM_MASK) : addr_q);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rd_act_q   <= 1'b0;
      wr_act_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= 8'h00;
    end else begin
      rd_act_q <= rd_act;
      wr_act_q <= wr_act;
      if (rd_ev && (sel_data || sel_ctrl)) data_oe_q <= 1'b1;
      else if (!rd_act)                    data_oe_q <= 1'b0;
      if (exec_vld && !exec_wr) data_out_q <= exec_ctrl ? {status_q, 5'b0} : buf_q;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pend_vld_q  <= 1'b0;
      pend_ctrl_q <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_dat_q  <= 8'h00;
    end else begin
      if (use_pend)   pend_vld_q <= stash;
      else if (stash) pend_vld_q <= 1'b1;
      if (stash) begin
        pend_ctrl_q <= bus_ctrl;
        pend_wr_q   <= wr_ev;
        pend_dat_q  <= data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_cram_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
      addr_q      <= '0;
      buf_q       <= 8'h00;
    end else if (idle) begin
      if (issue) begin
        state_q     <= S_REQ;
        mem_we_q    <= iss_we;
        mem_cram_q  <= iss_cram;
        mem_addr_q  <= iss_addr;
        mem_wdata_q <= exec_dat;
      end
      if (ctrl_wr2)            addr_q <= new_addr;
      if (exec_vld && iss_we)  buf_q  <= exec_dat;
    end else if (mem_ack) begin
      state_q <= S_IDLE;
      addr_q  <= addr_q + ADDR_W'(1);
      if (!mem_we_q) buf_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      latch_q  <= 8'h00;
      flag_q   <= 1'b0;
      code_q   <= 2'd0;
      regs_q   <= '0;
      status_q <= 3'b000;
    end else begin
      if (exec_vld && exec_ctrl && exec_wr && !flag_q) begin
        latch_q <= exec_dat;
        flag_q  <= 1'b1;
      end else if (exec_vld) begin
        flag_q <= 1'b0;
      end
      if (ctrl_wr2) code_q <= exec_dat[7:6];
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_we && reg_idx == 4'(i)) regs_q[8*i +: 8] <= latch_q;
      // A set pulse coinciding with the status read survives the clear.
      if (exec_vld && exec_ctrl && !exec_wr) status_q <= status_set;
      else                                   status_q <= status_q | status_set;
    end
  end

  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;
  assign mem_req   = (state_q == S_REQ);
  assign WAIT_L    = ~mem_req;
  assign mem_we    = mem_we_q;
  assign mem_cram  = mem_cram_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign regs      = regs_q;
  assign irq_L     = ~(status_q[2] & regs_q[13]);

endmodule
